// File: rtl/addr_seq_pkg.sv
// Shared constants for the operand/effective-address sequencer: decoded addressing modes,
// index select values and the sequencer state encoding.
package addr_seq_pkg;

  localparam logic [4:0] OP_IMM = 5'd1;
  localparam logic [4:0] OP_ZPG = 5'd2;
  localparam logic [4:0] OP_ZXY = 5'd3;
  localparam logic [4:0] OP_ABS = 5'd4;
  localparam logic [4:0] OP_AXY = 5'd5;
  localparam logic [4:0] OP_XIN = 5'd6;
  localparam logic [4:0] OP_INY = 5'd7;

  localparam logic IDX_X = 1'b0;
  localparam logic IDX_Y = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_OPL  = 4'd1,
    ST_OPH  = 4'd2,
    ST_IDX  = 4'd3,
    ST_PTRL = 4'd4,
    ST_PTRH = 4'd5,
    ST_FIX  = 4'd6,
    ST_RD   = 4'd7,
    ST_DWR  = 4'd8,
    ST_WR   = 4'd9,
    ST_DONE = 4'd10
  } seq_state_e;

  // Other op types belong to the control-flow sequencer.
  function automatic logic is_data_op(input logic [4:0] op);
    return (op == OP_IMM) || (op == OP_ZPG) || (op == OP_ZXY) || (op == OP_ABS) ||
           (op == OP_AXY) || (op == OP_XIN) || (op == OP_INY);
  endfunction

endpackage

// File: rtl/addr_seq_ea_add.sv
// 8-bit base+index adder used for zero-page indexing, pointer increment and low-byte indexing.
module ea_add (
  input  logic [7:0] base,
  input  logic [7:0] idx,
  output logic [7:0] sum,
  output logic       carry
);

  assign {carry, sum} = {1'b0, base} + {1'b0, idx};

endmodule

// File: rtl/addr_seq.sv
// Operand/effective-address sequencer: runs 6502-exact bus cycles for the data addressing modes
// and returns the read operand.
module addr_seq
  import addr_seq_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [4:0]    op_type,
  input  logic          idx_XY,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          rdy,
  input  logic [AW-1:0] pc,
  input  logic [7:0]    x,
  input  logic [7:0]    y,
  input  logic [7:0]    wdata,
  input  logic [7:0]    din,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic [7:0]    dout,
  output logic          pc_inc,
  output logic [7:0]    opnd,
  output logic          busy,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, pc_q, pc_d, ea_q, ea_d;
  logic          we_q, we_d, pc_inc_q, pc_inc_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]    dout_q, dout_d, opnd_q, opnd_d, lo_q, lo_d, ptr_q, ptr_d;
  logic [4:0]    op_q, op_d;
  logic          idx_sel_q, idx_sel_d, rd_q, rd_d, wr_q, wr_d;

  logic [7:0]    idx_s, zp_idx_s, lo_idx_s, zp_sum_s, ptr_inc_s, lo_sum_s;
  logic          zp_carry_s, ptr_carry_s, lo_carry_s, unused_carry_s;
  logic [AW-1:0] mem_ea_s, fix_addr_s, fix_ea_s;
  logic          go_mem_s, go_done_s;

  assign idx_s    = idx_sel_q ? y : x;
  assign zp_idx_s = (op_q == OP_XIN) ? x : idx_s;
  assign lo_idx_s = (op_q == OP_INY) ? y : idx_s;

  ea_add u_zp_add  (.base(lo_q),  .idx(zp_idx_s), .sum(zp_sum_s),  .carry(zp_carry_s));
  ea_add u_ptr_add (.base(ptr_q), .idx(8'd1),     .sum(ptr_inc_s), .carry(ptr_carry_s));
  ea_add u_lo_add  (.base(lo_q),  .idx(lo_idx_s), .sum(lo_sum_s),  .carry(lo_carry_s));

  // Zero-page arithmetic deliberately discards these carries.
  assign unused_carry_s = zp_carry_s ^ ptr_carry_s;

  // din carries the high byte when these are used (OPH of AXY, PTRH of INY).
  assign fix_addr_s = AW'({din, lo_sum_s});
  assign fix_ea_s   = AW'({din + {7'd0, lo_carry_s}, lo_sum_s});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    dout_d    = dout_q;
    pc_inc_d  = 1'b0;
    opnd_d    = opnd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    op_d      = op_q;
    idx_sel_d = idx_sel_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    pc_d      = pc_q;
    lo_d      = lo_q;
    ptr_d     = ptr_q;
    ea_d      = ea_q;
    go_mem_s  = 1'b0;
    go_done_s = 1'b0;
    mem_ea_s  = ea_q;

    case (state_q)
      ST_IDLE: begin
        addr_d = pc;
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (start && is_data_op(op_type)) begin
          op_d      = op_type;
          idx_sel_d = idx_XY;
          rd_d      = mem_rd;
          wr_d      = mem_wr;
          pc_d      = pc;
          pc_inc_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_OPL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPL: begin
        lo_d  = din;
        ptr_d = din;
        case (op_q)
          OP_IMM: begin
            opnd_d    = din;
            go_done_s = 1'b1;
          end
          OP_ZPG: begin
            go_mem_s = 1'b1;
            mem_ea_s = AW'(din);
          end
          OP_ZXY, OP_XIN: begin
            state_d = ST_IDX;
            addr_d  = AW'(din);
          end
          OP_ABS, OP_AXY: begin
            state_d  = ST_OPH;
            addr_d   = pc_q + AW'(1);
            pc_inc_d = 1'b1;
          end
          OP_INY: begin
            state_d = ST_PTRL;
            addr_d  = AW'(din);
          end
          default: go_done_s = 1'b1;
        endcase
      end
      ST_OPH, ST_PTRH: begin
        if ((op_q == OP_AXY) || (op_q == OP_INY)) begin
          // Page crossing, or any write, costs the extra FIX dummy read.
          if (lo_carry_s || wr_q) begin
            state_d = ST_FIX;
            addr_d  = fix_addr_s;
            ea_d    = fix_ea_s;
          end else begin
            go_mem_s = 1'b1;
            mem_ea_s = fix_ea_s;
          end
        end else begin
          go_mem_s = 1'b1;
          mem_ea_s = AW'({din, lo_q});
        end
      end
      ST_IDX: begin
        if (op_q == OP_XIN) begin
          state_d = ST_PTRL;
          ptr_d   = zp_sum_s;
          addr_d  = AW'(zp_sum_s);
        end else begin
          go_mem_s = 1'b1;
          mem_ea_s = AW'(zp_sum_s);
        end
      end
      ST_PTRL: begin
        lo_d    = din;
        state_d = ST_PTRH;
        addr_d  = AW'(ptr_inc_s);
      end
      ST_FIX: begin
        go_mem_s = 1'b1;
        mem_ea_s = ea_q;
      end
      ST_RD: begin
        opnd_d = din;
        if (wr_q) begin
          state_d = ST_DWR;
          we_d    = 1'b1;
          dout_d  = din;
        end else begin
          go_done_s = 1'b1;
        end
      end
      ST_DWR: begin
        state_d = ST_WR;
        we_d    = 1'b1;
        dout_d  = wdata;
      end
      ST_WR: go_done_s = 1'b1;
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = pc;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // Store-only ops skip the read; everything else (including RMW) reads first.
    if (go_mem_s) begin
      state_d = (wr_q && !rd_q) ? ST_WR : ST_RD;
      addr_d  = mem_ea_s;
      ea_d    = mem_ea_s;
      we_d    = wr_q && !rd_q;
      dout_d  = wdata;
    end else if (go_done_s) begin
      state_d = ST_DONE;
      addr_d  = pc;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      state_d = state_d;
    end
  end

  // rdy low freezes every register; only the single-cycle pulses drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dout_q    <= 8'd0;
      pc_inc_q  <= 1'b0;
      opnd_q    <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= 5'd0;
      idx_sel_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      pc_q      <= '0;
      lo_q      <= 8'd0;
      ptr_q     <= 8'd0;
      ea_q      <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      dout_q    <= dout_d;
      pc_inc_q  <= pc_inc_d;
      opnd_q    <= opnd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_q      <= op_d;
      idx_sel_q <= idx_sel_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pc_q      <= pc_d;
      lo_q      <= lo_d;
      ptr_q     <= ptr_d;
      ea_q      <= ea_d;
    end else begin
      pc_inc_q <= 1'b0;
      done_q   <= 1'b0;
    end
  end

  assign addr   = addr_q;
  assign we     = we_q;
  assign dout   = dout_q;
  assign pc_inc = pc_inc_q;
  assign opnd   = opnd_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_addr_seq.sv
// Bench for addr_seq: directed 6502 examples plus randomized instructions checked against
// a bus-cycle reference model built from the addressing-mode rules.
module tb_addr_seq;
  import addr_seq_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, idx_XY = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, rdy = 1'b1;
  logic [4:0]  op_type = 5'd0;
  logic [15:0] pc = 16'h0123;
  logic [7:0]  x = 8'd0, y = 8'd0, wdata = 8'd0;
  logic [7:0]  din;
  logic [15:0] addr;
  logic        we, pc_inc, busy, done;
  logic [7:0]  dout, opnd;

  logic [7:0]  mem [0:65535];
  assign din = mem[addr];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] eq_addr[$];
  bit          eq_we[$];
  logic [7:0]  eq_dout[$];
  bit          eq_pci[$];
  logic [7:0]  model_opnd;

  logic [15:0] obs_addr [0:31];
  logic        obs_we   [0:31];
  logic [7:0]  obs_dout [0:31];

  addr_seq #(.AW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .idx_XY(idx_XY),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .rdy(rdy), .pc(pc), .x(x), .y(y),
    .wdata(wdata), .din(din), .addr(addr), .we(we), .dout(dout),
    .pc_inc(pc_inc), .opnd(opnd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] a, input bit w, input logic [7:0] d, input bit pci);
    eq_addr.push_back(a);
    eq_we.push_back(w);
    eq_dout.push_back(d);
    eq_pci.push_back(pci);
  endtask

  // Reference: list every bus cycle the instruction should produce, in order.
  task automatic model_build(input logic [4:0] op, input logic isel, input logic rd, input logic wr,
                             input logic [15:0] pcv, input logic [7:0] xv, input logic [7:0] yv,
                             input logic [7:0] wd);
    logic [7:0]  b1, idx, p, d;
    logic [15:0] base, ea;
    eq_addr.delete(); eq_we.delete(); eq_dout.delete(); eq_pci.delete();
    idx = isel ? yv : xv;
    b1 = mem[pcv];
    push(pcv, 1'b0, 8'd0, 1'b1);
    ea = 16'd0;
    if (op == OP_IMM) begin
      model_opnd = b1;
      return;
    end
    case (op)
      OP_ZPG: ea = {8'h00, b1};
      OP_ZXY: begin
        push({8'h00, b1}, 1'b0, 8'd0, 1'b0);
        p = b1 + idx;
        ea = {8'h00, p};
      end
      OP_ABS: begin
        push(pcv + 16'd1, 1'b0, 8'd0, 1'b1);
        ea = {mem[pcv + 16'd1], b1};
      end
      OP_AXY: begin
        push(pcv + 16'd1, 1'b0, 8'd0, 1'b1);
        base = {mem[pcv + 16'd1], b1};
        ea = base + {8'h00, idx};
        if ((ea[15:8] != base[15:8]) || wr) push({base[15:8], ea[7:0]}, 1'b0, 8'd0, 1'b0);
      end
      OP_XIN: begin
        push({8'h00, b1}, 1'b0, 8'd0, 1'b0);
        p = b1 + xv;
        push({8'h00, p}, 1'b0, 8'd0, 1'b0);
        push({8'h00, 8'(p + 8'd1)}, 1'b0, 8'd0, 1'b0);
        ea = {mem[{8'h00, 8'(p + 8'd1)}], mem[{8'h00, p}]};
      end
      default: begin
        push({8'h00, b1}, 1'b0, 8'd0, 1'b0);
        push({8'h00, 8'(b1 + 8'd1)}, 1'b0, 8'd0, 1'b0);
        base = {mem[{8'h00, 8'(b1 + 8'd1)}], mem[{8'h00, b1}]};
        ea = base + {8'h00, yv};
        if ((ea[15:8] != base[15:8]) || wr) push({base[15:8], ea[7:0]}, 1'b0, 8'd0, 1'b0);
      end
    endcase
    if (wr && !rd) begin
      push(ea, 1'b1, wd, 1'b0);
    end else begin
      d = mem[ea];
      push(ea, 1'b0, 8'd0, 1'b0);
      model_opnd = d;
      if (wr) begin
        push(ea, 1'b1, d, 1'b0);
        push(ea, 1'b1, wd, 1'b0);
      end
    end
  endtask

  task automatic run_txn(input logic [4:0] op, input logic isel, input logic rd, input logic wr,
                         input logic [15:0] pcv, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [7:0] wd, input bit restart, input bit start_in_done,
                         output int ncyc);
    int k;
    model_build(op, isel, rd, wr, pcv, xv, yv, wd);
    @(negedge clk);
    start = 1'b1; op_type = op; idx_XY = isel; mem_rd = rd; mem_wr = wr;
    pc = pcv; x = xv; y = yv; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      obs_addr[k] = addr; obs_we[k] = we; obs_dout[k] = dout;
      if (k < eq_addr.size()) begin
        chk("cyc_addr", 32'(addr), 32'(eq_addr[k]));
        chk("cyc_we", 32'(we), 32'(eq_we[k]));
        chk("cyc_pc_inc", 32'(pc_inc), 32'(eq_pci[k]));
        if (eq_we[k]) chk("cyc_dout", 32'(dout), 32'(eq_dout[k]));
        chk("cyc_busy", 32'(busy), 32'd1);
      end
      start = restart && (k == 0);
      if (start) begin
        op_type = OP_IMM; mem_rd = ~rd;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    ncyc = k;
    chk("cycles", 32'(k), 32'(eq_addr.size()));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_we", 32'(we), 32'd0);
    if (start_in_done) begin
      start = 1'b1; op_type = OP_ZPG; mem_rd = 1'b1; mem_wr = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("done_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_start_busy2", 32'(busy), 32'd0);
    end else begin
      @(negedge clk);
    end
    chk("done_clear", 32'(done), 32'd0);
    chk("opnd", 32'(opnd), 32'(model_opnd));
  endtask

  task automatic run_invalid(input logic [4:0] op, input logic [15:0] pcv);
    @(negedge clk);
    start = 1'b1; op_type = op; pc = pcv; mem_rd = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("inv_busy", 32'(busy), 32'd0);
    chk("inv_addr", 32'(addr), 32'(pcv));
    @(negedge clk);
    chk("inv_busy2", 32'(busy), 32'd0);
    chk("inv_done", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic [4:0] ops [0:6];
    ops[0] = OP_IMM; ops[1] = OP_ZPG; ops[2] = OP_ZXY; ops[3] = OP_ABS;
    ops[4] = OP_AXY; ops[5] = OP_XIN; ops[6] = OP_INY;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_opnd", 32'(opnd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    model_opnd = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_addr", 32'(addr), 32'h0123);

    // LDA #$42
    mem[16'h0200] = 8'h42;
    run_txn(OP_IMM, IDX_X, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, n);
    chk("t1_cycles", 32'(n), 32'd1);
    chk("t1_addr", 32'(obs_addr[0]), 32'h0200);
    chk("t1_opnd", 32'(opnd), 32'h42);

    // LDA $10,X with zero-page wrap
    mem[16'h0200] = 8'h10;
    run_txn(OP_ZXY, IDX_X, 1'b1, 1'b0, 16'h0200, 8'hF5, 8'h00, 8'h00, 1'b0, 1'b0, n);
    chk("t2_cycles", 32'(n), 32'd3);
    chk("t2_dummy", 32'(obs_addr[1]), 32'h0010);
    chk("t2_ea", 32'(obs_addr[2]), 32'h0005);

    // LDA $12FF,Y with and without page crossing
    mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'h12;
    run_txn(OP_AXY, IDX_Y, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, n);
    chk("t3_cycles", 32'(n), 32'd4);
    chk("t3_fix", 32'(obs_addr[2]), 32'h1200);
    chk("t3_ea", 32'(obs_addr[3]), 32'h1300);
    run_txn(OP_AXY, IDX_Y, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, n);
    chk("t3b_cycles", 32'(n), 32'd3);
    chk("t3b_ea", 32'(obs_addr[2]), 32'h12FF);

    // INC $FFFF,X: high byte wraps to page 0
    mem[16'h0200] = 8'hFF; mem[16'h0201] = 8'hFF; mem[16'h0000] = 8'h5A;
    run_txn(OP_AXY, IDX_X, 1'b1, 1'b1, 16'h0200, 8'h01, 8'h00, 8'hC3, 1'b0, 1'b0, n);
    chk("t4_cycles", 32'(n), 32'd6);
    chk("t4_fix", 32'(obs_addr[2]), 32'hFF00);
    chk("t4_rd", 32'(obs_addr[3]), 32'h0000);
    chk("t4_rd_we", 32'(obs_we[3]), 32'd0);
    chk("t4_dwr_we", 32'(obs_we[4]), 32'd1);
    chk("t4_dwr_dout", 32'(obs_dout[4]), 32'h5A);
    chk("t4_wr_addr", 32'(obs_addr[5]), 32'h0000);
    chk("t4_wr_dout", 32'(obs_dout[5]), 32'hC3);

    // LDA ($FF),Y: pointer high byte wraps within zero page
    mem[16'h0200] = 8'hFF; mem[16'h00FF] = 8'hF8; mem[16'h0000] = 8'h20; mem[16'h2108] = 8'h77;
    run_txn(OP_INY, IDX_X, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1, n);
    chk("t5_cycles", 32'(n), 32'd5);
    chk("t5_ptrl", 32'(obs_addr[1]), 32'h00FF);
    chk("t5_ptrh", 32'(obs_addr[2]), 32'h0000);
    chk("t5_fix", 32'(obs_addr[3]), 32'h2008);
    chk("t5_ea", 32'(obs_addr[4]), 32'h2108);
    chk("t5_opnd", 32'(opnd), 32'h77);

    run_invalid(5'd0, 16'h0345);
    run_invalid(5'd12, 16'h0456);

    for (int t = 0; t < 60; t++) begin
      int sel, mode;
      logic r, w;
      sel = $urandom_range(0, 7);
      mode = $urandom_range(0, 2);
      r = (mode != 1); w = (mode != 0);
      if (sel == 7) begin
        run_invalid(5'($urandom_range(8, 31)), 16'($urandom));
      end else begin
        if (ops[sel] == OP_IMM) begin r = 1'b1; w = 1'b0; end
        run_txn(ops[sel], 1'($urandom), r, w, 16'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), n);
      end
    end

    // Stall inside OPH, then reset during FIX
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
    @(negedge clk);
    start = 1'b1; op_type = OP_AXY; idx_XY = IDX_Y; mem_rd = 1'b1; mem_wr = 1'b0;
    pc = 16'h0300; y = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t6_oph_addr", 32'(addr), 32'h0301);
    chk("t6_oph_pc_inc", 32'(pc_inc), 32'd1);
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t6_stall_addr", 32'(addr), 32'h0301);
      chk("t6_stall_we", 32'(we), 32'd0);
      chk("t6_stall_pc_inc", 32'(pc_inc), 32'd0);
      chk("t6_stall_busy", 32'(busy), 32'd1);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("t6_fix_addr", 32'(addr), 32'h1200);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_addr", 32'(addr), 32'd0);
    chk("t6_rst_we", 32'(we), 32'd0);
    chk("t6_rst_dout", 32'(dout), 32'd0);
    chk("t6_rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("t6_rst_opnd", 32'(opnd), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("t6_post_done", 32'(done), 32'd0);
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_addr", 32'(addr), 32'h0300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
